// File: rtl/spi_fib_rx_framer.sv
// Collects one NDN interest/data packet from the SPI byte core and replays it to fib_table.
// Optional inter-byte idle timeout in COLLECT is enabled with `define SPI_FIB_RX_TIMEOUT_EN.
module spi_fib_rx_framer #(
    parameter int PREFIX_BYTES   = 8,
    parameter int DATA_BYTES     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spi_rx_byte,
    input  logic       spi_rx_valid,
    output logic       spi_rx_ready,
    output logic       RX_valid,
    output logic [7:0] data_SPI_to_FIB,
    output logic       pkt_done,
    output logic [7:0] drop_count,
    output logic       rx_timeout
);
    localparam int         L_MAX        = 1 + PREFIX_BYTES + DATA_BYTES;
    localparam logic [5:0] LEN_INTEREST = 6'(1 + PREFIX_BYTES);
    localparam logic [5:0] LEN_DATA     = 6'(L_MAX);

    typedef enum logic [1:0] {IDLE, COLLECT, START, SEND} state_t;

    state_t     state;
    logic [5:0] idx;
    logic [5:0] pkt_len;
    logic [7:0] pkt_buf [L_MAX];
    logic       accept;

    assign accept = spi_rx_valid && spi_rx_ready;

    // Buffer needs no reset; idx is 0 in IDLE so byte 0 always lands at the front.
    always_ff @(posedge clk) begin
        if (accept) begin
            pkt_buf[idx] <= spi_rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= 8'd0;
        end else if (spi_rx_valid && !spi_rx_ready && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

`ifdef SPI_FIB_RX_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= 6'd0;
            pkt_len         <= LEN_DATA;
            spi_rx_ready    <= 1'b1;
            RX_valid        <= 1'b0;
            data_SPI_to_FIB <= 8'd0;
            pkt_done        <= 1'b0;
`ifdef SPI_FIB_RX_TIMEOUT_EN
            idle_cnt        <= '0;
            rx_timeout      <= 1'b0;
`endif
        end else begin
            RX_valid <= 1'b0;
`ifdef SPI_FIB_RX_TIMEOUT_EN
            rx_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        pkt_len <= spi_rx_byte[6] ? LEN_INTEREST : LEN_DATA;
                        idx     <= 6'd1;
                        state   <= COLLECT;
`ifdef SPI_FIB_RX_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        idx <= idx + 6'd1;
`ifdef SPI_FIB_RX_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (idx + 6'd1 == pkt_len) begin
                            state        <= START;
                            RX_valid     <= 1'b1;
                            spi_rx_ready <= 1'b0;
                        end
                    end
`ifdef SPI_FIB_RX_TIMEOUT_EN
                    else if (idle_cnt == TMO_LAST) begin
                        state      <= IDLE;
                        idx        <= 6'd0;
                        idle_cnt   <= '0;
                        rx_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                START: begin
                    data_SPI_to_FIB <= pkt_buf[0];
                    idx             <= 6'd1;
                    pkt_done        <= 1'b0;
                    state           <= SEND;
                end
                SEND: begin
                    // pkt_done high means the last byte is on the bus this cycle.
                    if (pkt_done) begin
                        state           <= IDLE;
                        idx             <= 6'd0;
                        data_SPI_to_FIB <= 8'd0;
                        pkt_done        <= 1'b0;
                        spi_rx_ready    <= 1'b1;
                    end else begin
                        data_SPI_to_FIB <= pkt_buf[idx];
                        idx             <= idx + 6'd1;
                        pkt_done        <= (idx + 6'd1 == pkt_len);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
